wm8731_config_sequencer: RTL and testbench



---
 rtl/wm8731_pkg.sv | 60 ++++++
 rtl/i2c_byte_engine.sv | 105 ++++++++++
 rtl/wm8731_config_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_wm8731_config_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared constants for the WM8731 configuration sequencer: states, bit-engine
// commands, codec register map and the power-up register table.
package wm8731_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD, START_C, BIT, ACK, STOP_C, GAP, RUN, FAIL
  } state_e;

  // One command = one bus primitive; CMD_BYTE covers 8 data bits, CMD_ACK the 9th clock.
  typedef enum logic [2:0] {
    CMD_START, CMD_BYTE, CMD_ACK, CMD_STOP, CMD_IDLE
  } i2c_cmd_e;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } reg_wr_t;

  localparam logic [6:0] R_LINVOL  = 7'h00;
  localparam logic [6:0] R_RINVOL  = 7'h01;
  localparam logic [6:0] R_LHPVOL  = 7'h02;
  localparam logic [6:0] R_RHPVOL  = 7'h03;
  localparam logic [6:0] R_ANAPATH = 7'h04;
  localparam logic [6:0] R_DIGPATH = 7'h05;
  localparam logic [6:0] R_PWRDN   = 7'h06;
  localparam logic [6:0] R_IFACE   = 7'h07;
  localparam logic [6:0] R_SRATE   = 7'h08;
  localparam logic [6:0] R_ACTIVE  = 7'h09;
  localparam logic [6:0] R_RESET   = 7'h0F;

  localparam int INIT_LEN = 11;

  // Power-up order: soft reset first, interface active last.
  function automatic reg_wr_t init_entry(input logic [3:0] i);
    case (i)
      4'd0:    return '{R_RESET,   9'h000};
      4'd1:    return '{R_LINVOL,  9'h017};
      4'd2:    return '{R_RINVOL,  9'h017};
      4'd3:    return '{R_LHPVOL,  9'h079};
      4'd4:    return '{R_RHPVOL,  9'h079};
      4'd5:    return '{R_ANAPATH, 9'h012};
      4'd6:    return '{R_DIGPATH, 9'h000};
      4'd7:    return '{R_PWRDN,   9'h000};
      4'd8:    return '{R_IFACE,   9'h002};
      4'd9:    return '{R_SRATE,   9'h002};
      default: return '{R_ACTIVE,  9'h001};
    endcase
  endfunction

  // Byte sel of a write frame: device address/W, reg+data MSB, data LSBs.
  function automatic logic [7:0] frame_byte(input logic [1:0] sel, input logic [6:0] dev,
                                            input reg_wr_t w);
    case (sel)
      2'd0:    return {dev, 1'b0};
      2'd1:    return {w.addr, w.data[8]};
      default: return w.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_byte_engine.sv
// I2C bit engine: quarter-bit tick divider, executes one bus primitive per
// command (start, 8-bit byte, ack clock, stop, idle bit) and samples ACK.
module i2c_byte_engine
  import wm8731_pkg::*;
#(
  parameter int DIV = 46
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       cmd_vld,
  input  i2c_cmd_e   cmd,
  input  logic [7:0] cmd_byte,
  input  logic       sda_in,
  output logic       cmd_done,
  output logic       nack,
  output logic       scl,
  output logic       sda_oe
);

  localparam int DW = $clog2(DIV + 1);

  logic          busy;
  i2c_cmd_e      op;
  logic [7:0]    sh;
  logic [1:0]    q;
  logic [2:0]    nbit;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          scl_d, oe_d;

  // Divider restarts with each command so every quarter is exactly DIV cycles.
  assign tick = busy && (div_cnt == DW'(DIV - 1));

  // Line levels for the current primitive and quarter.
  always_comb begin
    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (op)
      CMD_START: oe_d = q[1];                 // SDA falls in q2 with SCL high
      CMD_BYTE: begin
        scl_d = (q == 2'd1) || (q == 2'd2);
        oe_d  = ~sh[7];
      end
      CMD_ACK:   scl_d = (q == 2'd1) || (q == 2'd2);
      CMD_STOP: begin
        scl_d = (q != 2'd0);
        oe_d  = (q != 2'd3);                  // SDA rises in q3 with SCL high
      end
      default: ;
    endcase
  end

  // Command sequencing: quarter/bit counters, shift and ACK sample.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy     <= 1'b0;
      op       <= CMD_IDLE;
      sh       <= '0;
      q        <= '0;
      nbit     <= '0;
      div_cnt  <= '0;
      nack     <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      if (cmd_vld && !busy) begin
        busy    <= 1'b1;
        op      <= cmd;
        sh      <= cmd_byte;
        q       <= '0;
        nbit    <= '0;
        div_cnt <= '0;
      end else if (busy) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) begin
          if (q == 2'd2 && op == CMD_ACK) nack <= sda_in;
          if (q == 2'd3) begin
            q <= '0;
            if (op == CMD_BYTE && nbit != 3'd7) begin
              nbit <= nbit + 3'd1;
              sh   <= {sh[6:0], 1'b0};
            end else begin
              busy     <= 1'b0;
              cmd_done <= 1'b1;
            end
          end else begin
            q <= q + 2'd1;
          end
        end
      end
    end
  end

  // Registered bus outputs; hold last level between commands.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl    <= 1'b1;
      sda_oe <= 1'b0;
    end else if (busy) begin
      scl    <= scl_d;
      sda_oe <= oe_d;
    end
  end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// WM8731 configuration sequencer: writes the power-up table over I2C with
// per-frame NACK retry, then services runtime register writes.
module wm8731_config_sequencer
  import wm8731_pkg::*;
#(
  parameter int         CLK_RATE_HZ = 18432203,
  parameter int         I2C_RATE_HZ = 100000,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         RETRY_MAX   = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic       CFG_REQ,
  input  logic [6:0] CFG_ADDR,
  input  logic [8:0] CFG_DATA,
  output logic       CFG_ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR,
  output logic       CODEC_ENABLE,
  output logic       I2C_SCLK,
  output logic       I2C_SDAT_OE,
  input  logic       I2C_SDAT_IN
);

  localparam int         DIV_RAW = CLK_RATE_HZ / (4 * I2C_RATE_HZ);
  localparam int         DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [7:0] RMAX    = 8'(RETRY_MAX);
  localparam logic [3:0] LAST    = 4'(INIT_LEN - 1);

  state_e     state, state_n;
  logic [3:0] idx, idx_n;
  logic [1:0] sel, sel_n;
  logic [7:0] tries, tries_n;
  logic       nack_f, nack_f_n;
  logic       rt, rt_n;
  reg_wr_t    frame, frame_n;
  logic       done_n, err_n, cen_n;
  logic       cmd_vld, cmd_vld_n;
  i2c_cmd_e   cmd, cmd_n;
  logic [7:0] cmd_byte, cmd_byte_n;
  logic       eng_done, eng_nack;

  i2c_byte_engine #(.DIV(DIV)) u_eng (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .cmd_vld  (cmd_vld),
    .cmd      (cmd),
    .cmd_byte (cmd_byte),
    .sda_in   (I2C_SDAT_IN),
    .cmd_done (eng_done),
    .nack     (eng_nack),
    .scl      (I2C_SCLK),
    .sda_oe   (I2C_SDAT_OE)
  );

  assign BUSY = !(state == IDLE || state == RUN || state == FAIL);

  // Next state, frame bookkeeping, retry policy and engine commands.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    sel_n      = sel;
    tries_n    = tries;
    nack_f_n   = nack_f;
    rt_n       = rt;
    frame_n    = frame;
    done_n     = DONE;
    err_n      = ERROR;
    cen_n      = CODEC_ENABLE;
    cmd_vld_n  = 1'b0;
    cmd_n      = cmd;
    cmd_byte_n = cmd_byte;
    CFG_ACK    = 1'b0;
    case (state)
      IDLE, RUN, FAIL: begin
        if (START) begin
          state_n = LOAD;
          idx_n   = '0;
          tries_n = '0;
          rt_n    = 1'b0;
          done_n  = 1'b0;
          err_n   = 1'b0;
          cen_n   = 1'b0;
        end else if (state == RUN && CFG_REQ) begin
          state_n = LOAD;
          tries_n = '0;
          rt_n    = 1'b1;
          frame_n = {CFG_ADDR, CFG_DATA};
        end
      end
      LOAD: begin
        if (!rt) frame_n = init_entry(idx);
        nack_f_n  = 1'b0;
        sel_n     = '0;
        state_n   = START_C;
        cmd_vld_n = 1'b1;
        cmd_n     = CMD_START;
      end
      START_C: if (eng_done) begin
        state_n    = BIT;
        cmd_vld_n  = 1'b1;
        cmd_n      = CMD_BYTE;
        cmd_byte_n = frame_byte(2'd0, DEV_ADDR, frame);
      end
      BIT: if (eng_done) begin
        state_n   = ACK;
        cmd_vld_n = 1'b1;
        cmd_n     = CMD_ACK;
      end
      ACK: if (eng_done) begin
        cmd_vld_n = 1'b1;
        if (eng_nack || sel == 2'd2) begin
          state_n  = STOP_C;
          nack_f_n = eng_nack;
          cmd_n    = CMD_STOP;
        end else begin
          state_n    = BIT;
          sel_n      = sel + 2'd1;
          cmd_n      = CMD_BYTE;
          cmd_byte_n = frame_byte(sel + 2'd1, DEV_ADDR, frame);
        end
      end
      STOP_C: if (eng_done) begin
        state_n   = GAP;
        cmd_vld_n = 1'b1;
        cmd_n     = CMD_IDLE;
      end
      GAP: if (eng_done) begin
        if (nack_f) begin
          if (tries == RMAX) begin
            state_n = FAIL;
            err_n   = 1'b1;
            done_n  = 1'b0;
            cen_n   = 1'b0;
          end else begin
            tries_n = tries + 8'd1;
            state_n = LOAD;
          end
        end else begin
          tries_n = '0;
          if (rt) begin
            CFG_ACK = 1'b1;
            rt_n    = 1'b0;
            state_n = RUN;
          end else if (idx == LAST) begin
            state_n = RUN;
            done_n  = 1'b1;
            cen_n   = 1'b1;
          end else begin
            idx_n   = idx + 4'd1;
            state_n = LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      idx          <= '0;
      sel          <= '0;
      tries        <= '0;
      nack_f       <= 1'b0;
      rt           <= 1'b0;
      frame        <= '0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
      CODEC_ENABLE <= 1'b0;
      cmd_vld      <= 1'b0;
      cmd          <= CMD_IDLE;
      cmd_byte     <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      sel          <= sel_n;
      tries        <= tries_n;
      nack_f       <= nack_f_n;
      rt           <= rt_n;
      frame        <= frame_n;
      DONE         <= done_n;
      ERROR        <= err_n;
      CODEC_ENABLE <= cen_n;
      cmd_vld      <= cmd_vld_n;
      cmd          <= cmd_n;
      cmd_byte     <= cmd_byte_n;
    end
  end

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Bench for wm8731_config_sequencer: an I2C slave model decodes frames off the
// bus, and an arithmetic model of the register table predicts them.
module tb_wm8731_config_sequencer;

  localparam int QB  = 1200 / (4 * 100);   // quarter-bit length in cycles
  localparam int LIM = 12000;

  logic       CLK = 1'b0;
  logic       RESET_N, START, CFG_REQ;
  logic [6:0] CFG_ADDR;
  logic [8:0] CFG_DATA;
  logic       CFG_ACK, BUSY, DONE, ERROR, CODEC_ENABLE, I2C_SCLK, I2C_SDAT_OE, I2C_SDAT_IN;
  logic       slave_pull;

  wm8731_config_sequencer #(
    .CLK_RATE_HZ(1200), .I2C_RATE_HZ(100), .DEV_ADDR(7'h1A), .RETRY_MAX(3)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .CFG_REQ(CFG_REQ),
    .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA), .CFG_ACK(CFG_ACK), .BUSY(BUSY),
    .DONE(DONE), .ERROR(ERROR), .CODEC_ENABLE(CODEC_ENABLE), .I2C_SCLK(I2C_SCLK),
    .I2C_SDAT_OE(I2C_SDAT_OE), .I2C_SDAT_IN(I2C_SDAT_IN)
  );

  always #5 CLK = ~CLK;

  // Open-drain bus: low if either side pulls.
  assign I2C_SDAT_IN = ~(I2C_SDAT_OE | slave_pull);

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave / bus monitor ----------------
  // Frames recorded as {byte_count[7:0], bytes right-aligned[23:0]}.
  logic [31:0] frames[$];
  int     mode = 0;              // 0 ack all, 1 nack all, 2 nack first R4 data byte once
  bit     r4_nacked = 0;
  longint cyc = 0, last_stop = -1, min_gap = 1000000;
  int     ack_cyc = 0;
  bit     rt_win = 0, cen_drop = 0;

  initial begin
    logic scl_p, sda_p, sda, in_fr, nk;
    int bcnt, cur_n;
    logic [7:0] sh;
    logic [23:0] cur_b;
    slave_pull = 1'b0;
    scl_p = 1'b1; sda_p = 1'b1; in_fr = 1'b0; bcnt = 0; cur_n = 0; cur_b = '0; sh = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      sda = ~(I2C_SDAT_OE | slave_pull);
      if (CFG_ACK) ack_cyc++;
      if (rt_win && !CODEC_ENABLE) cen_drop = 1;
      if (RESET_N !== 1'b1) begin
        slave_pull = 1'b0; in_fr = 1'b0; bcnt = 0;
      end else if (scl_p && I2C_SCLK && sda_p && !sda) begin
        in_fr = 1'b1; bcnt = 0; cur_n = 0; cur_b = '0;
        if (last_stop >= 0 && cyc - last_stop < min_gap) min_gap = cyc - last_stop;
      end else if (scl_p && I2C_SCLK && !sda_p && sda && in_fr) begin
        frames.push_back({8'(cur_n), cur_b});
        in_fr = 1'b0; last_stop = cyc;
      end else if (!scl_p && I2C_SCLK && in_fr && bcnt < 8) begin
        sh = {sh[6:0], sda}; bcnt++;
      end else if (scl_p && !I2C_SCLK && in_fr) begin
        if (bcnt == 8) begin
          cur_b = {cur_b[15:0], sh}; cur_n++;
          nk = (mode == 1) || (mode == 2 && !r4_nacked && cur_n == 2 && sh == 8'h08);
          if (mode == 2 && nk) r4_nacked = 1;
          slave_pull = !nk; bcnt = 9;
        end else if (bcnt == 9) begin
          slave_pull = 1'b0; bcnt = 0;
        end
      end
      scl_p = I2C_SCLK; sda_p = sda;
    end
  end

  // ---------------- reference model ----------------
  int t_reg [11] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int t_dat [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h002, 'h002, 'h001};
  logic [31:0] exp_q[$];

  // A write of data d to register r; n < 3 models a frame cut short by a NACK.
  function automatic logic [31:0] model_frame(int r, int d, int n);
    int full;
    full = ('h1A * 2) * 65536 + (r * 2 + d / 256) * 256 + d % 256;
    return (32'(n) << 24) | 32'(full >> (8 * (3 - n)));
  endfunction

  task automatic push_init(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back(model_frame(t_reg[i], t_dat[i], 3));
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_count"}, frames.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < frames.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), frames[i], exp_q[i]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < LIM && BUSY; c++) @(negedge CLK);
    check({tag, "_idle"}, BUSY, 1'b0);
  endtask

  task automatic wait_frames(input int n, input string tag);
    for (int c = 0; c < LIM && frames.size() < n; c++) @(negedge CLK);
    check({tag, "_frames_seen"}, frames.size() >= n, 1'b1);
  endtask

  // Holds CFG_REQ until CFG_ACK (or timeout); got reports whether ACK came.
  task automatic cfg_write(input logic [6:0] a, input logic [8:0] d, output bit got);
    @(negedge CLK);
    CFG_ADDR = a; CFG_DATA = d; CFG_REQ = 1'b1;
    got = 0;
    for (int c = 0; c < LIM && !got; c++) begin
      @(negedge CLK);
      if (CFG_ACK) got = 1;
    end
    CFG_REQ = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic restart_to_run(input string tag);
    mode = 0;
    pulse_start();
    wait_idle(tag);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit got;
    int a0;
    logic [6:0] ra;
    logic [8:0] rd;

    RESET_N = 1'b0; START = 1'b0; CFG_REQ = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    repeat (3) @(negedge CLK);
    check("rst_scl", I2C_SCLK, 1'b1);
    check("rst_oe", I2C_SDAT_OE, 1'b0);
    check("rst_status", {BUSY, DONE, ERROR, CODEC_ENABLE, CFG_ACK}, 5'b0);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // Full init with an always-ACK slave; a START while busy must be ignored.
    frames.delete(); exp_q.delete(); last_stop = -1; min_gap = 1000000;
    pulse_start();
    check("init_busy", BUSY, 1'b1);
    repeat (60) @(negedge CLK);
    pulse_start();
    wait_idle("init");
    push_init(0, 10);
    cmp_frames("init");
    check("init_status", {DONE, CODEC_ENABLE, ERROR, BUSY}, 4'b1100);
    check("init_gap_ok", min_gap >= 4 * QB, 1'b1);

    // Runtime write R2 <- 07F.
    frames.delete(); exp_q.delete();
    a0 = ack_cyc; rt_win = 1; cen_drop = 0;
    cfg_write(7'h02, 9'h07F, got);
    check("rt_ack_seen", got, 1'b1);
    check("rt_ack_cycles", ack_cyc - a0, 1);
    exp_q.push_back(model_frame(2, 'h7F, 3));
    cmp_frames("rt");

    // Random runtime writes.
    for (int k = 0; k < 3; k++) begin
      frames.delete(); exp_q.delete();
      ra = 7'($urandom_range(0, 127)); rd = 9'($urandom_range(0, 511));
      a0 = ack_cyc;
      cfg_write(ra, rd, got);
      check($sformatf("rnd%0d_ack_cycles", k), ack_cyc - a0, 1);
      exp_q.push_back(model_frame(int'(ra), int'(rd), 3));
      cmp_frames($sformatf("rnd%0d", k));
    end
    check("rt_codec_held", cen_drop, 1'b0);
    check("rt_done_held", DONE, 1'b1);
    rt_win = 0;

    // Restart from RUN with one NACK on R4's data byte.
    frames.delete(); exp_q.delete();
    mode = 2; r4_nacked = 0;
    pulse_start();
    check("restart_clear", {DONE, ERROR, CODEC_ENABLE}, 3'b000);
    wait_idle("r4");
    push_init(0, 4);
    exp_q.push_back(model_frame(4, 'h012, 2));
    push_init(5, 10);
    cmp_frames("r4");
    check("r4_done", {DONE, ERROR}, 2'b10);

    // Runtime request raised during init entry 3 waits for the whole table.
    frames.delete(); exp_q.delete();
    mode = 0;
    pulse_start();
    wait_frames(3, "early");
    ra = 7'($urandom_range(0, 127)); rd = 9'($urandom_range(0, 511));
    cfg_write(ra, rd, got);
    check("early_ack_seen", got, 1'b1);
    push_init(0, 10);
    exp_q.push_back(model_frame(int'(ra), int'(rd), 3));
    cmp_frames("early");

    // Always-NACK slave: four attempts of R15, then failure.
    frames.delete(); exp_q.delete();
    mode = 1;
    pulse_start();
    for (int c = 0; c < LIM && !ERROR; c++) @(negedge CLK);
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_frame(15, 0, 1));
    cmp_frames("nack");
    check("nack_status", {ERROR, CODEC_ENABLE, BUSY, DONE}, 4'b1000);

    // Runtime write that exhausts retries: no CFG_ACK, FAIL.
    restart_to_run("rtf_init");
    frames.delete(); exp_q.delete();
    mode = 1; a0 = ack_cyc;
    @(negedge CLK);
    CFG_ADDR = 7'h05; CFG_DATA = 9'h006; CFG_REQ = 1'b1;
    for (int c = 0; c < LIM && !ERROR; c++) @(negedge CLK);
    CFG_REQ = 1'b0;
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 4; i++) exp_q.push_back(model_frame(5, 6, 1));
    cmp_frames("rtf");
    check("rtf_no_ack", ack_cyc - a0, 0);
    check("rtf_status", {ERROR, CODEC_ENABLE, BUSY}, 3'b100);

    // Reset in the middle of a data byte, then a clean restart.
    frames.delete(); exp_q.delete();
    mode = 0;
    pulse_start();
    wait_frames(1, "mid");
    repeat (40) @(negedge CLK);
    for (int c = 0; c < 400 && !(!I2C_SCLK && I2C_SDAT_OE); c++) @(negedge CLK);
    check("mid_pre_lines", {I2C_SCLK, I2C_SDAT_OE}, 2'b01);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_lines", {I2C_SCLK, I2C_SDAT_OE}, 2'b10);
    check("mid_rst_status", {BUSY, DONE, ERROR, CODEC_ENABLE}, 4'b0);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    frames.delete();
    repeat (3) @(negedge CLK);
    pulse_start();
    wait_frames(1, "post");
    check("post_first", frames[0], model_frame(15, 0, 3));
    wait_idle("post");
    check("post_done", DONE, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
